// File: rtl/gen_sweep_ctrl_pkg.sv
// gen_sweep_ctrl_pkg: shared constants for the sweep sequencer (kiwi gen include).
// Latency: n/a (types, encodings and helpers only).
// Backpressure: n/a.
// Contents: cfg_sel encodings, FSM state encoding, default widths, max(v,1)-1 helper.
package gen_sweep_ctrl_pkg;

  localparam int GEN_PINC_W  = 48;
  localparam int GEN_ATTN_W  = 18;
  localparam int GEN_CNT_W   = 16;
  localparam int GEN_DWELL_W = 32;

  // cfg_sel register map
  localparam logic [2:0] GEN_SWP_START_H = 3'd0;
  localparam logic [2:0] GEN_SWP_START_L = 3'd1;
  localparam logic [2:0] GEN_SWP_STEP_H  = 3'd2;
  localparam logic [2:0] GEN_SWP_STEP_L  = 3'd3;
  localparam logic [2:0] GEN_SWP_NSTEPS  = 3'd4;
  localparam logic [2:0] GEN_SWP_DWELL   = 3'd5;
  localparam logic [2:0] GEN_SWP_ATTN    = 3'd6;
  localparam logic [2:0] GEN_SWP_MODE    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } swp_state_e;

  // Zero is treated as one, so the result is the terminal count / last index.
  function automatic logic [31:0] min1_m1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/gen_sweep_ctrl_if.sv
// gen_sweep_ctrl_if: config/control bus and generator-facing outputs of the sweep sequencer.
// Latency: n/a (wires only).
// Backpressure: none; strobes are single-cycle pulses already in adc_clk.
// master: CPU-side driver (cfg_*, start, stop) and observer of the outputs.
// slave : the sequencer itself.
interface gen_sweep_ctrl_if #(
  parameter int PINC_W = 48,
  parameter int ATTN_W = 18,
  parameter int CNT_W  = 16
);
  logic              cfg_wr;
  logic [2:0]        cfg_sel;
  logic [31:0]       cfg_data;
  logic              start;
  logic              stop;
  logic [PINC_W-1:0] phase_inc;
  logic [ATTN_W-1:0] attn;
  logic              upd;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  step_idx;

  modport master (
    output cfg_wr, cfg_sel, cfg_data, start, stop,
    input  phase_inc, attn, upd, busy, done, step_idx
  );

  modport slave (
    input  cfg_wr, cfg_sel, cfg_data, start, stop,
    output phase_inc, attn, upd, busy, done, step_idx
  );
endinterface

// File: rtl/gen_sweep_timer.sv
// gen_sweep_timer: dwell down-counter with synchronous load and terminal-count flag.
// Latency: load value visible one cycle after load; tc is combinational from the count.
// Backpressure: none; count parks at zero when enabled without a reload.
// Ports: clk/rst, load + load_val, en (decrement), tc (count == 0), cnt.
module gen_sweep_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/gen_sweep_ctrl.sv
// gen_sweep_ctrl: frequency-sweep sequencer driving DDS phase increment and attenuation.
// Latency: start -> phase_inc/upd valid 1 cycle; each step held exactly max(dwell,1) cycles.
// Backpressure: none; start ignored while sweeping, stop always wins.
// Ports: adc_clk, reset (async, active-high), bus (gen_sweep_ctrl_if.slave).
// Option: define GEN_SWEEP_LOOP_EN to enable loop mode via cfg_sel 7 bit 0.
module gen_sweep_ctrl
  import gen_sweep_ctrl_pkg::*;
#(
  parameter int PINC_W = GEN_PINC_W,
  parameter int ATTN_W = GEN_ATTN_W,
  parameter int CNT_W  = GEN_CNT_W
) (
  input  logic             adc_clk,
  input  logic             reset,
  gen_sweep_ctrl_if.slave  bus
);

  // Shadow configuration, written by the CPU in any state
  logic [PINC_W-1:0]      sh_start;
  logic [PINC_W-1:0]      sh_step;
  logic [CNT_W-1:0]       sh_nsteps;
  logic [GEN_DWELL_W-1:0] sh_dwell;
  logic [ATTN_W-1:0]      sh_attn;

  // Active sweep parameters, captured on start
  logic [PINC_W-1:0]      act_start;
  logic [PINC_W-1:0]      act_step;
  logic [CNT_W-1:0]       act_last;
  logic [GEN_DWELL_W-1:0] act_dwell_m1;
  logic                   loop_en;

  // Output registers
  logic [PINC_W-1:0]      phase_q;
  logic [ATTN_W-1:0]      attn_q;
  logic [CNT_W-1:0]       idx_q;
  logic                   upd_q;

  swp_state_e state, state_nxt;
  logic do_load, do_step, do_restart, do_clear;

  logic                   tmr_tc;
  logic                   tmr_load;
  logic [GEN_DWELL_W-1:0] tmr_val;
  logic [GEN_DWELL_W-1:0] tmr_cnt;

  logic attn_wr;
  assign attn_wr = bus.cfg_wr && (bus.cfg_sel == GEN_SWP_ATTN);

  // Shadow registers
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      sh_start  <= '0;
      sh_step   <= '0;
      sh_nsteps <= '0;
      sh_dwell  <= '0;
      sh_attn   <= '0;
    end else if (bus.cfg_wr) begin
      case (bus.cfg_sel)
        GEN_SWP_START_H: sh_start[PINC_W-1:16] <= bus.cfg_data[PINC_W-17:0];
        GEN_SWP_START_L: sh_start[15:0]        <= bus.cfg_data[15:0];
        GEN_SWP_STEP_H:  sh_step[PINC_W-1:16]  <= bus.cfg_data[PINC_W-17:0];
        GEN_SWP_STEP_L:  sh_step[15:0]         <= bus.cfg_data[15:0];
        GEN_SWP_NSTEPS:  sh_nsteps             <= bus.cfg_data[CNT_W-1:0];
        GEN_SWP_DWELL:   sh_dwell              <= bus.cfg_data;
        GEN_SWP_ATTN:    sh_attn               <= bus.cfg_data[ATTN_W-1:0];
        default:         ;
      endcase
    end
  end

`ifdef GEN_SWEEP_LOOP_EN
  logic sh_loop;
  logic act_loop;

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      sh_loop  <= 1'b0;
      act_loop <= 1'b0;
    end else begin
      if (bus.cfg_wr && (bus.cfg_sel == GEN_SWP_MODE)) begin
        sh_loop <= bus.cfg_data[0];
      end
      // Mode is latched with the rest of the sweep so a mid-sweep write waits for the next start
      if (do_load) begin
        act_loop <= sh_loop;
      end
    end
  end

  assign loop_en = act_loop;
`else
  assign loop_en = 1'b0;
`endif

  // State register
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_step    = 1'b0;
    do_restart = 1'b0;
    do_clear   = 1'b0;
    if (bus.stop) begin
      state_nxt = ST_IDLE;
      do_clear  = 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_nxt = ST_DWELL;
            do_load   = 1'b1;
          end
        end
        ST_DWELL: begin
          if (tmr_tc) begin
            if (idx_q == act_last) begin
              if (loop_en) begin
                do_restart = 1'b1;
              end else begin
                state_nxt = ST_DONE;
              end
            end else begin
              do_step = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          do_clear  = 1'b1;
        end
      endcase
    end
  end

  // On start the reload comes straight from the shadow dwell; later reloads reuse the captured one.
  always_comb begin
    tmr_load = do_load | do_step | do_restart | do_clear;
    tmr_val  = act_dwell_m1;
    if (do_clear) begin
      tmr_val = '0;
    end else if (do_load) begin
      tmr_val = min1_m1(sh_dwell);
    end
  end

  gen_sweep_timer #(
    .W (GEN_DWELL_W)
  ) u_timer (
    .clk      (adc_clk),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state == ST_DWELL),
    .tc       (tmr_tc),
    .cnt      (tmr_cnt)
  );

  // Sweep datapath
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      phase_q      <= '0;
      idx_q        <= '0;
      upd_q        <= 1'b0;
      act_start    <= '0;
      act_step     <= '0;
      act_last     <= '0;
      act_dwell_m1 <= '0;
    end else begin
      upd_q <= 1'b0;
      if (do_clear) begin
        phase_q <= '0;
        idx_q   <= '0;
      end else if (do_load) begin
        phase_q      <= sh_start;
        idx_q        <= '0;
        upd_q        <= 1'b1;
        act_start    <= sh_start;
        act_step     <= sh_step;
        act_last     <= CNT_W'(min1_m1(32'(sh_nsteps)));
        act_dwell_m1 <= min1_m1(sh_dwell);
      end else if (do_step) begin
        // Modulo 2^PINC_W: a negative step is just the two's complement add
        phase_q <= phase_q + act_step;
        idx_q   <= idx_q + 1'b1;
        upd_q   <= 1'b1;
      end else if (do_restart) begin
        phase_q <= act_start;
        idx_q   <= '0;
        upd_q   <= 1'b1;
      end
    end
  end

  // Attenuation follows a write on the next cycle, but is held at zero whenever the FSM is idle
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      attn_q <= '0;
    end else if (state_nxt == ST_IDLE) begin
      attn_q <= '0;
    end else if (attn_wr) begin
      attn_q <= bus.cfg_data[ATTN_W-1:0];
    end else begin
      attn_q <= sh_attn;
    end
  end

  assign bus.phase_inc = phase_q;
  assign bus.attn      = attn_q;
  assign bus.upd       = upd_q;
  assign bus.step_idx  = idx_q;
  assign bus.busy      = (state == ST_DWELL);
  assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_gen_sweep_ctrl.sv
// tb_gen_sweep_ctrl: directed-vector bench for the sweep sequencer.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_gen_sweep_ctrl;
  import gen_sweep_ctrl_pkg::*;

  logic adc_clk = 1'b0;
  logic reset   = 1'b1;

  always #5 adc_clk = ~adc_clk;

  gen_sweep_ctrl_if #(.PINC_W(48), .ATTN_W(18), .CNT_W(16)) bus ();

  gen_sweep_ctrl #(.PINC_W(48), .ATTN_W(18), .CNT_W(16)) dut (
    .adc_clk (adc_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt;
  logic [47:0] exp_pinc;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [2:0] sel, input logic [31:0] data);
    bus.cfg_wr   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_data = data;
    tick(1);
    bus.cfg_wr   = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p);
    bus.start = s;
    bus.stop  = p;
    tick(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  // Counts upd pulses over n cycles
  task automatic count_upd(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.upd) cnt++;
      tick(1);
    end
  endtask

  initial begin
    bus.cfg_wr   = 1'b0;
    bus.cfg_sel  = 3'd0;
    bus.cfg_data = 32'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;

    // Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check_vec("rst_pinc", 64'(bus.phase_inc), 64'h0);
    check_vec("rst_attn", 64'(bus.attn), 64'h0);
    check_vec("rst_busy", 64'(bus.busy), 64'h0);
    check_vec("rst_done", 64'(bus.done), 64'h0);
    check_vec("rst_idx", 64'(bus.step_idx), 64'h0);
    count_upd(6, upd_cnt);
    check_vec("idle_no_upd", 64'(upd_cnt), 64'h0);

    // Basic sweep: start 0x10000000, step 0x100, 4 steps, dwell 3
    cfg(GEN_SWP_START_H, 32'h0000_1000);
    cfg(GEN_SWP_START_L, 32'h0000_0000);
    cfg(GEN_SWP_STEP_H,  32'h0000_0000);
    cfg(GEN_SWP_STEP_L,  32'h0000_0100);
    cfg(GEN_SWP_NSTEPS,  32'd4);
    cfg(GEN_SWP_DWELL,   32'd3);
    cfg(GEN_SWP_ATTN,    32'h0001_FFFF);
    tick(1);
    check_vec("idle_attn_forced0", 64'(bus.attn), 64'h0);
    pulse(1'b1, 1'b0);
    upd_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      exp_pinc = 48'h1000_0000 + 48'((c < 12 ? c / 3 : 3) * 256);
      check_vec($sformatf("sweep_pinc_c%0d", c), 64'(bus.phase_inc), 64'(exp_pinc));
      check_vec($sformatf("sweep_upd_c%0d", c), 64'(bus.upd), ((c < 12) && (c % 3 == 0)) ? 64'h1 : 64'h0);
      check_vec($sformatf("sweep_done_c%0d", c), 64'(bus.done), (c >= 12) ? 64'h1 : 64'h0);
      check_vec($sformatf("sweep_busy_c%0d", c), 64'(bus.busy), (c < 12) ? 64'h1 : 64'h0);
      if (bus.upd) upd_cnt++;
      tick(1);
    end
    check_vec("sweep_upd_total", 64'(upd_cnt), 64'd4);
    check_vec("done_idx", 64'(bus.step_idx), 64'd3);
    check_vec("done_attn", 64'(bus.attn), 64'h1FFFF);
    cfg(GEN_SWP_ATTN, 32'h0000_0123);
    check_vec("attn_live_update", 64'(bus.attn), 64'h123);

    // Negative step wraps modulo 2^48
    cfg(GEN_SWP_START_H, 32'h0000_0000);
    cfg(GEN_SWP_START_L, 32'h0000_0000);
    cfg(GEN_SWP_STEP_H,  32'hFFFF_FFFF);
    cfg(GEN_SWP_STEP_L,  32'h0000_FFFF);
    cfg(GEN_SWP_NSTEPS,  32'd2);
    cfg(GEN_SWP_DWELL,   32'd1);
    pulse(1'b1, 1'b0);
    check_vec("wrap_pinc0", 64'(bus.phase_inc), 64'h0);
    check_vec("wrap_done_clr", 64'(bus.done), 64'h0);
    tick(1);
    check_vec("wrap_pinc1", 64'(bus.phase_inc), 64'hFFFF_FFFF_FFFF);
    check_vec("wrap_upd1", 64'(bus.upd), 64'h1);
    tick(1);
    check_vec("wrap_done", 64'(bus.done), 64'h1);
    check_vec("wrap_hold", 64'(bus.phase_inc), 64'hFFFF_FFFF_FFFF);

    // dwell = 0, nsteps = 0; a dwell write coincident with start must not be used
    cfg(GEN_SWP_NSTEPS, 32'd0);
    cfg(GEN_SWP_DWELL,  32'd0);
    bus.cfg_wr   = 1'b1;
    bus.cfg_sel  = GEN_SWP_DWELL;
    bus.cfg_data = 32'd5;
    pulse(1'b1, 1'b0);
    bus.cfg_wr   = 1'b0;
    check_vec("z_upd", 64'(bus.upd), 64'h1);
    check_vec("z_busy", 64'(bus.busy), 64'h1);
    check_vec("z_pinc", 64'(bus.phase_inc), 64'h0);
    tick(1);
    check_vec("z_done", 64'(bus.done), 64'h1);
    count_upd(4, upd_cnt);
    check_vec("z_no_more_upd", 64'(upd_cnt), 64'h0);

    // Stop and start together mid-sweep: stop wins
    cfg(GEN_SWP_START_H, 32'h0000_0000);
    cfg(GEN_SWP_START_L, 32'h0000_1234);
    cfg(GEN_SWP_STEP_H,  32'h0000_0000);
    cfg(GEN_SWP_STEP_L,  32'h0000_0001);
    cfg(GEN_SWP_NSTEPS,  32'd10);
    cfg(GEN_SWP_DWELL,   32'd4);
    pulse(1'b1, 1'b0);
    tick(5);
    check_vec("mid_idx", 64'(bus.step_idx), 64'd1);
    check_vec("mid_pinc", 64'(bus.phase_inc), 64'h1235);
    pulse(1'b1, 1'b0);
    check_vec("start_in_dwell_ignored", 64'(bus.phase_inc), 64'h1235);
    pulse(1'b1, 1'b1);
    check_vec("stop_pinc", 64'(bus.phase_inc), 64'h0);
    check_vec("stop_attn", 64'(bus.attn), 64'h0);
    check_vec("stop_busy", 64'(bus.busy), 64'h0);
    check_vec("stop_idx", 64'(bus.step_idx), 64'h0);
    check_vec("stop_done", 64'(bus.done), 64'h0);
    count_upd(6, upd_cnt);
    check_vec("stop_no_restart", 64'(upd_cnt), 64'h0);
    check_vec("stop_still_idle", 64'(bus.busy), 64'h0);

    // Async reset at step 2
    pulse(1'b1, 1'b0);
    tick(8);
    check_vec("pre_rst_idx", 64'(bus.step_idx), 64'd2);
    check_vec("pre_rst_pinc", 64'(bus.phase_inc), 64'h1236);
    check_vec("pre_rst_attn", 64'(bus.attn), 64'h123);
    #2;
    reset = 1'b1;
    #1;
    check_vec("arst_pinc", 64'(bus.phase_inc), 64'h0);
    check_vec("arst_attn", 64'(bus.attn), 64'h0);
    check_vec("arst_idx", 64'(bus.step_idx), 64'h0);
    check_vec("arst_busy", 64'(bus.busy), 64'h0);
    check_vec("arst_upd", 64'(bus.upd), 64'h0);
    tick(2);
    reset = 1'b0;
    tick(1);

`ifdef GEN_SWEEP_LOOP_EN
    // Loop mode: start, +step, +2*step, start, ...
    cfg(GEN_SWP_MODE,    32'd1);
    cfg(GEN_SWP_START_H, 32'h0000_0000);
    cfg(GEN_SWP_START_L, 32'h0000_0100);
    cfg(GEN_SWP_STEP_H,  32'h0000_0000);
    cfg(GEN_SWP_STEP_L,  32'h0000_0010);
    cfg(GEN_SWP_NSTEPS,  32'd3);
    cfg(GEN_SWP_DWELL,   32'd2);
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 14; c++) begin
      exp_pinc = 48'h100 + 48'(((c / 2) % 3) * 16);
      check_vec($sformatf("loop_pinc_c%0d", c), 64'(bus.phase_inc), 64'(exp_pinc));
      check_vec($sformatf("loop_upd_c%0d", c), 64'(bus.upd), (c % 2 == 0) ? 64'h1 : 64'h0);
      check_vec($sformatf("loop_done_c%0d", c), 64'(bus.done), 64'h0);
      tick(1);
    end
    pulse(1'b0, 1'b1);
    check_vec("loop_stop_pinc", 64'(bus.phase_inc), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gen_sweep_ctrl.md
Name: gen_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the adc_clk-domain signal generator (DDS plus attenuator multiply).
- Holds CPU-loaded sweep configuration and drives the generator's 48-bit phase increment and 18-bit attenuation.
- Steps the phase increment from a start value by a signed step every dwell interval, for N steps.
- Configuration writes arrive already synchronised into adc_clk (single-cycle pulses).

Parameters:
- PINC_W, 48, phase-increment width (DDS accumulator width)
- ATTN_W, 18, attenuation word width (signed)
- CNT_W, 16, width of step count and step index

Ports:
- adc_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- cfg_wr  in  1  one-cycle config write strobe
- cfg_sel  in  3  register select: 0 start[47:16], 1 start[15:0], 2 step[47:16], 3 step[15:0], 4 nsteps, 5 dwell, 6 attn
- cfg_data  in  32  write data; narrower fields take the LSBs
- start  in  1  one-cycle pulse that starts a sweep
- stop  in  1  one-cycle pulse that aborts the sweep
- phase_inc  out  PINC_W  to DDS pinc_in
- attn  out  ATTN_W  to generator attenuation multiplier
- upd  out  1  one-cycle pulse whenever phase_inc changes
- busy  out  1  high in DWELL
- done  out  1  high in DONE until next start or stop
- step_idx  out  CNT_W  current step number, 0-based

Behaviour:
- Reset: all outputs 0, shadow config registers 0, state IDLE.
- Config writes land in shadow registers in any state. start, step, nsteps and dwell are sampled only at start. attn updates the output register one cycle after the write, except in IDLE, where attn is forced to 0.
- States: IDLE, DWELL, DONE.
  - IDLE/DONE + start: next cycle phase_inc = start value, step_idx = 0, dwell_cnt = max(dwell,1)-1, upd = 1, state = DWELL, done = 0.
  - DWELL, dwell_cnt != 0: decrement dwell_cnt.
  - DWELL, dwell_cnt == 0, step_idx == max(nsteps,1)-1: state = DONE; phase_inc and attn hold (final tone continues).
  - DWELL, dwell_cnt == 0, otherwise: phase_inc += step (two's complement, modulo 2^PINC_W, wraps silently); step_idx += 1; reload dwell_cnt; upd = 1.
  - Any state + stop: state = IDLE next cycle; phase_inc = 0, attn output = 0, step_idx = 0, done = 0.
- Every dwell interval is exactly max(dwell,1) cycles; nsteps = 0 behaves as 1.
- Simultaneous events:
  - start and stop in the same cycle: stop wins.
  - start during DWELL: ignored.
  - cfg_wr in the same cycle as start: the start samples the old shadow value.
- Latency: start to phase_inc valid is 1 cycle. upd is coincident with the new phase_inc.
- Async reset mid-sweep returns everything to reset values immediately; no partial step is retained.

Optional Feature:
- Macro: GEN_SWEEP_LOOP_EN.
- When defined, a shadow register at cfg_sel 7, bit 0 enables loop mode. With loop mode set, the final-step transition reloads the start value (step_idx = 0, upd = 1) instead of entering DONE, and done never asserts.
- When undefined, cfg_sel 7 writes are ignored and sweeps always terminate in DONE.

Decomposition:
- Shared package (kiwi gen include):
  - cfg_sel encodings (GEN_SWP_START_H, GEN_SWP_START_L, GEN_SWP_STEP_H, GEN_SWP_STEP_L, GEN_SWP_NSTEPS, GEN_SWP_DWELL, GEN_SWP_ATTN, GEN_SWP_MODE)
  - state encoding localparams
  - PINC_W/ATTN_W defaults
- One natural sub-module: gen_sweep_timer, a dwell down-counter with load/terminal-count.
- Everything else (state machine, 48-bit adder, shadow registers) stays in the top.

Test Plan:
- Reset release → phase_inc = 0, attn = 0, busy = 0, done = 0, upd never pulses with no start.
- start = 0x0000_1000_0000, step = 0x100, nsteps = 4, dwell = 3, attn = 0x1FFFF:
  - phase_inc sequence 0x10000000, 0x10000100, 0x10000200, 0x10000300, each held 3 cycles;
  - 4 upd pulses;
  - done asserts 12 cycles after the first upd.
- step = 0xFFFF_FFFF_FFFF (−1), start = 0, nsteps = 2 → second phase_inc = 0xFFFF_FFFF_FFFF (wrap).
- dwell = 0, nsteps = 0 → exactly one upd, DONE one cycle later.
- Mid-sweep: stop and start pulsed in the same cycle → IDLE, phase_inc = 0, attn = 0, and no new sweep begins. Async reset asserted at step 2 → all outputs 0 immediately.
- With GEN_SWEEP_LOOP_EN and mode = 1, nsteps = 3, dwell = 2 → phase_inc cycles start, +step, +2·step, start, …; done stays 0; upd every 2 cycles.
